// File: rtl/register_serializer_if.sv
// Parallel-load / serial-out handshake bundle for register_serializer.
// The slave side is the serializer; the master side loads words and consumes bits.
interface register_serializer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic             busy;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             done;

  modport slave (
    input  in,
    input  load,
    input  out_ready,
    output busy,
    output out_bit,
    output out_valid,
    output done
  );

  modport master (
    output in,
    output load,
    output out_ready,
    input  busy,
    input  out_bit,
    input  out_valid,
    input  done
  );
endinterface

// File: rtl/register_serializer.sv
// register_serializer: captures a WIDTH-bit word on load (IDLE only) and streams it
// one bit per accepted valid/ready transfer, then pulses done for one cycle.
// Optional feature macro REGISTER_SERIALIZER_PARITY_EN appends an even-parity bit,
// computed from the captured word at load time, after the data bits.
module register_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  register_serializer_if.slave bus
);

`ifdef REGISTER_SERIALIZER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load_acc;
  logic             w_xfer;
  logic             w_last;
  logic             w_end_bit;
  logic             w_ser_bit;

  // Move the shift register one place toward the output end, zero-filling.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  assign w_load_acc = (r_state == S_IDLE) && bus.load;
  assign w_xfer     = (r_state == S_SHIFT) && bus.out_ready;
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_end_bit  = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];

`ifdef REGISTER_SERIALIZER_PARITY_EN
  logic r_parity;

  // Parity of the captured word, held for the extra trailing bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        r_parity <= 1'b0;
    else if (w_load_acc) r_parity <= ^bus.in;
  end

  assign w_ser_bit = (r_cnt == CNT_W'(WIDTH)) ? r_parity : w_end_bit;
`else
  assign w_ser_bit = w_end_bit;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state decode: the last accepted bit ends the word, DONE lasts one cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.load) w_next_state = S_SHIFT;
      S_SHIFT: if (w_xfer && w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Shift register and bit counter: load in IDLE, advance on each accepted bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_load_acc) begin
      r_shreg <= bus.in;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_shreg <= shift_out(r_shreg);
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = (r_state == S_SHIFT);
  assign bus.out_bit   = (r_state == S_SHIFT) && w_ser_bit;
  assign bus.done      = (r_state == S_DONE);

endmodule

// File: tb/tb_register_serializer.sv
// Self-checking bench for register_serializer: one MSB-first and one LSB-first
// instance, checked against a bit-order reference model built from the word value.
module tb_register_serializer;
  localparam int W = 16;
`ifdef REGISTER_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  register_serializer_if #(.WIDTH(W)) ifm ();
  register_serializer_if #(.WIDTH(W)) ifl ();

  register_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifm.slave)
  );

  register_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifl.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference: i-th transmitted bit of a word (index W is the parity bit).
  function automatic logic model_bit(input logic [W-1:0] w, input bit lsb, input int i);
    if (i >= W) return ^w;
    if (lsb)    return w[i];
    return w[W-1-i];
  endfunction

  function automatic logic [31:0] model_stream(input logic [W-1:0] w, input bit lsb);
    logic [31:0] e;
    e = '0;
    for (int i = 0; i < NB; i++) e[i] = model_bit(w, lsb, i);
    return e;
  endfunction

  task automatic set_in(input bit lsb, input logic [W-1:0] w, input logic ld);
    if (lsb) begin ifl.in = w; ifl.load = ld; end
    else     begin ifm.in = w; ifm.load = ld; end
  endtask

  task automatic set_ready(input bit lsb, input logic r);
    if (lsb) ifl.out_ready = r;
    else     ifm.out_ready = r;
  endtask

  task automatic get_out(input bit lsb, output logic v, output logic b, output logic bz, output logic d);
    if (lsb) begin v = ifl.out_valid; b = ifl.out_bit; bz = ifl.busy; d = ifl.done; end
    else     begin v = ifm.out_valid; b = ifm.out_bit; bz = ifm.busy; d = ifm.done; end
  endtask

  // Drives one word and records what the consumer saw; mode 0 ready=1,
  // mode 1 ready pattern 1,0,0,..., mode 2 random ready. inj: cycle to pulse load with FFFF.
  task automatic run_word(input bit lsb, input logic [W-1:0] w, input int mode, input int inj,
                          output logic [31:0] got, output int n_acc, output int last_acc,
                          output int done_cyc, output int done_cnt, output int busy_cnt,
                          output int stall_bad, output int zero_bad);
    logic v, b, bz, d, r, pv, pb, pr;
    int cyc;
    got = '0; n_acc = 0; last_acc = -1; done_cyc = -1; done_cnt = 0;
    busy_cnt = 0; stall_bad = 0; zero_bad = 0;
    pv = 0; pb = 0; pr = 0; cyc = 0;
    @(negedge clock);
    set_in(lsb, w, 1'b1);
    set_ready(lsb, 1'b0);
    while (cyc < 400) begin
      @(negedge clock);
      cyc++;
      set_in(lsb, W'($urandom), 1'b0);
      if (cyc == inj) set_in(lsb, 16'hFFFF, 1'b1);
      get_out(lsb, v, b, bz, d);
      if (pv && !pr && (!v || b !== pb)) stall_bad++;
      if (!v && b !== 1'b0) zero_bad++;
      if (bz) busy_cnt++;
      if (d) begin done_cnt++; done_cyc = cyc; end
      case (mode)
        0:       r = 1'b1;
        1:       r = ((cyc - 1) % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      set_ready(lsb, r);
      if (v && r) begin
        if (n_acc < 32) got[n_acc] = b;
        n_acc++;
        last_acc = cyc;
      end
      pv = v; pb = b; pr = r;
      if (done_cyc > 0 && cyc > done_cyc + 1) break;
    end
    set_in(lsb, '0, 1'b0);
    set_ready(lsb, 1'b0);
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL timeout: no done within %0d cycles for word %h", cyc, w);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({ifm.busy, ifm.out_valid, ifm.out_bit, ifm.done} !== 4'b0) begin
      errors++; $display("FAIL reset_msb_outputs: got %b expected 0000",
                         {ifm.busy, ifm.out_valid, ifm.out_bit, ifm.done});
    end
    checks++;
    if ({ifl.busy, ifl.out_valid, ifl.out_bit, ifl.done} !== 4'b0) begin
      errors++; $display("FAIL reset_lsb_outputs: got %b expected 0000",
                         {ifl.busy, ifl.out_valid, ifl.out_bit, ifl.done});
    end
  endtask

  task automatic test_msb_full_rate;
    logic [31:0] got, exp;
    int n, la, dc, dn, bc, sb, zb;
    run_word(1'b0, 16'h8001, 0, -1, got, n, la, dc, dn, bc, sb, zb);
    exp = model_stream(16'h8001, 1'b0);
    checks++;
    if (got[NB-1:0] !== exp[NB-1:0]) begin
      errors++; $display("FAIL msb_8001_stream: got %h expected %h", got[NB-1:0], exp[NB-1:0]);
    end
    checks++;
    if (dc !== NB + 1) begin errors++; $display("FAIL msb_8001_done_cycle: got %0d expected %0d", dc, NB + 1); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL msb_8001_done_count: got %0d expected 1", dn); end
    checks++;
    if (bc !== NB + 1) begin errors++; $display("FAIL msb_8001_busy_span: got %0d expected %0d", bc, NB + 1); end
    checks++;
    if (zb !== 0) begin errors++; $display("FAIL msb_8001_idle_bit_zero: got %0d expected 0", zb); end
  endtask

  task automatic test_lsb_first;
    logic [31:0] got, exp;
    int n, la, dc, dn, bc, sb, zb;
    run_word(1'b1, 16'h00FF, 0, -1, got, n, la, dc, dn, bc, sb, zb);
    exp = model_stream(16'h00FF, 1'b1);
    checks++;
    if (got[NB-1:0] !== exp[NB-1:0]) begin
      errors++; $display("FAIL lsb_00ff_stream: got %h expected %h", got[NB-1:0], exp[NB-1:0]);
    end
    checks++;
    if (dn !== 1 || n !== NB) begin
      errors++; $display("FAIL lsb_00ff_counts: got done=%0d bits=%0d expected done=1 bits=%0d", dn, n, NB);
    end
  endtask

  task automatic test_stall;
    logic [31:0] got, exp;
    int n, la, dc, dn, bc, sb, zb;
    run_word(1'b0, 16'hA5A5, 1, -1, got, n, la, dc, dn, bc, sb, zb);
    exp = model_stream(16'hA5A5, 1'b0);
    checks++;
    if (got[NB-1:0] !== exp[NB-1:0]) begin
      errors++; $display("FAIL stall_a5a5_stream: got %h expected %h", got[NB-1:0], exp[NB-1:0]);
    end
    checks++;
    if (n !== NB) begin errors++; $display("FAIL stall_a5a5_transfers: got %0d expected %0d", n, NB); end
    checks++;
    if (sb !== 0) begin errors++; $display("FAIL stall_a5a5_hold: got %0d violations expected 0", sb); end
    checks++;
    if (dc !== la + 1 || dn !== 1) begin
      errors++; $display("FAIL stall_a5a5_done: got cycle %0d count %0d expected cycle %0d count 1", dc, dn, la + 1);
    end
  endtask

  task automatic test_load_ignored;
    logic [31:0] got, exp;
    int n, la, dc, dn, bc, sb, zb;
    run_word(1'b0, 16'h1234, 0, 4, got, n, la, dc, dn, bc, sb, zb);
    exp = model_stream(16'h1234, 1'b0);
    checks++;
    if (got[NB-1:0] !== exp[NB-1:0]) begin
      errors++; $display("FAIL load_ignored_stream: got %h expected %h", got[NB-1:0], exp[NB-1:0]);
    end
    checks++;
    if (dc !== NB + 1 || bc !== NB + 1) begin
      errors++; $display("FAIL load_ignored_timing: got done %0d busy %0d expected %0d", dc, bc, NB + 1);
    end
  endtask

  task automatic test_reset_mid_word;
    logic [31:0] got, exp;
    int n, la, dc, dn, bc, sb, zb, late;
    @(negedge clock);
    set_ready(1'b0, 1'b1);
    set_in(1'b0, 16'h7FFF, 1'b1);
    @(negedge clock);
    set_in(1'b0, 16'h0, 1'b0);
    repeat (4) @(negedge clock);
    @(posedge clock);
    #2;
    checks++;
    if (ifm.busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", ifm.busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ifm.busy, ifm.out_valid, ifm.out_bit, ifm.done} !== 4'b0) begin
      errors++; $display("FAIL midreset_outputs: got %b expected 0000",
                         {ifm.busy, ifm.out_valid, ifm.out_bit, ifm.done});
    end
    reset_n = 1'b1;
    late = 0;
    repeat (20) begin
      @(negedge clock);
      if (ifm.done || ifm.busy) late++;
    end
    checks++;
    if (late !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", late); end
    set_ready(1'b0, 1'b0);
    run_word(1'b0, 16'h0003, 0, -1, got, n, la, dc, dn, bc, sb, zb);
    exp = model_stream(16'h0003, 1'b0);
    checks++;
    if (got[NB-1:0] !== exp[NB-1:0] || dn !== 1) begin
      errors++; $display("FAIL midreset_reload_stream: got %h done %0d expected %h done 1",
                         got[NB-1:0], dn, exp[NB-1:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got, exp;
    int cyc, n;
    @(negedge clock);
    set_ready(1'b0, 1'b1);
    set_in(1'b0, 16'hC3C3, 1'b1);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) set_in(1'b0, 16'h0, 1'b0);
    end while (!ifm.done && cyc < 60);
    checks++;
    if (cyc !== NB + 1) begin errors++; $display("FAIL b2b_first_done: got cycle %0d expected %0d", cyc, NB + 1); end
    set_in(1'b0, 16'h5A0F, 1'b1);
    @(negedge clock);
    checks++;
    if (ifm.busy !== 1'b0) begin errors++; $display("FAIL b2b_load_in_done_ignored: got busy %b expected 0", ifm.busy); end
    @(negedge clock);
    set_in(1'b0, 16'h0, 1'b0);
    got = '0; n = 0; cyc = 0;
    while (!ifm.done && cyc < 60) begin
      if (ifm.out_valid) begin
        if (n < 32) got[n] = ifm.out_bit;
        n++;
      end
      @(negedge clock);
      cyc++;
    end
    exp = model_stream(16'h5A0F, 1'b0);
    checks++;
    if (got[NB-1:0] !== exp[NB-1:0] || n !== NB) begin
      errors++; $display("FAIL b2b_second_stream: got %h (%0d bits) expected %h (%0d bits)",
                         got[NB-1:0], n, exp[NB-1:0], NB);
    end
    set_ready(1'b0, 1'b0);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_random;
    logic [31:0] got, exp;
    logic [W-1:0] w;
    int n, la, dc, dn, bc, sb, zb;
    bit lsb;
    for (int k = 0; k < 8; k++) begin
      w   = W'($urandom);
      lsb = (k % 2) == 1;
      run_word(lsb, w, 2, -1, got, n, la, dc, dn, bc, sb, zb);
      exp = model_stream(w, lsb);
      checks++;
      if (got[NB-1:0] !== exp[NB-1:0] || n !== NB) begin
        errors++; $display("FAIL random_stream[%0d]: word %h lsb %0d got %h (%0d bits) expected %h",
                           k, w, lsb, got[NB-1:0], n, exp[NB-1:0]);
      end
      checks++;
      if (dc !== la + 1 || dn !== 1 || bc !== dc || sb !== 0 || zb !== 0) begin
        errors++; $display("FAIL random_handshake[%0d]: done %0d/%0d busy %0d stall %0d zero %0d expected done %0d/1 busy %0d 0 0",
                           k, dc, dn, bc, sb, zb, la + 1, dc);
      end
    end
  endtask

`ifdef REGISTER_SERIALIZER_PARITY_EN
  task automatic test_parity;
    logic [31:0] got;
    int n, la, dc, dn, bc, sb, zb;
    run_word(1'b0, 16'h0007, 0, -1, got, n, la, dc, dn, bc, sb, zb);
    checks++;
    if (got[W] !== 1'b1 || dc !== W + 2) begin
      errors++; $display("FAIL parity_0007: got bit %b done %0d expected bit 1 done %0d", got[W], dc, W + 2);
    end
    run_word(1'b0, 16'h0003, 0, -1, got, n, la, dc, dn, bc, sb, zb);
    checks++;
    if (got[W] !== 1'b0 || n !== W + 1) begin
      errors++; $display("FAIL parity_0003: got bit %b bits %0d expected bit 0 bits %0d", got[W], n, W + 1);
    end
  endtask
`endif

  initial begin
    ifm.in = '0; ifm.load = 1'b0; ifm.out_ready = 1'b0;
    ifl.in = '0; ifl.load = 1'b0; ifl.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    test_reset;
    reset_n = 1'b1;
    @(negedge clock);
    test_reset;
    test_msb_full_rate;
    test_lsb_first;
    test_stall;
    test_load_ignored;
    test_reset_mid_word;
    test_back_to_back;
    test_random;
`ifdef REGISTER_SERIALIZER_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
